// File: rtl/ts_word_aligner_pkg.sv
// Shared types and word-format constants for the timestamp word aligner.
// Used by ts_word_aligner and its testbench-facing build option TS_MONOTONIC_CHECK_EN.
package ts_word_aligner_pkg;

    typedef enum logic [1:0] {
        WAIT1 = 2'd0,
        WAIT2 = 2'd1,
        WAIT3 = 2'd2
    } state_t;

    localparam logic [3:0] IDX_LO  = 4'd1;
    localparam logic [3:0] IDX_MID = 4'd2;
    localparam logic [3:0] IDX_HI  = 4'd3;

    localparam int ID_MSB      = 31;
    localparam int ID_LSB      = 28;
    localparam int IDX_MSB     = 27;
    localparam int IDX_LSB     = 24;
    localparam int PAYLOAD_MSB = 23;
    localparam int PAYLOAD_LSB = 0;
    localparam int PAYLOAD_W   = PAYLOAD_MSB - PAYLOAD_LSB + 1;

    // Index the next in-order word must carry while in state s.
    function automatic logic [3:0] expected_idx(input state_t s);
        // NOTE: the default arm keeps the unused encoding defined; an incomplete case is how latches sneak in.
        case (s)
            WAIT1:   return IDX_LO;
            WAIT2:   return IDX_MID;
            WAIT3:   return IDX_HI;
            default: return IDX_LO;
        endcase
    endfunction

endpackage

// File: rtl/ts_word_aligner_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             CLK,
    input  logic             clr_n,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // NOTE: sequential state is written with <= only so every register samples pre-edge values.
    always_ff @(posedge CLK or negedge clr_n) begin
        if (!clr_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + ONE;
        end
    end

endmodule

// File: rtl/ts_word_aligner.sv
// Pops tagged 32-bit words, reassembles 3-word events into 64-bit timestamps on a valid/ready stream.
// Define TS_MONOTONIC_CHECK_EN to drop events whose timestamp does not strictly increase.
module ts_word_aligner
    import ts_word_aligner_pkg::*;
#(
    parameter logic [3:0] IDENTIFIER    = 4'b0101,
    parameter int         ERR_CNT_WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     FIFO_EMPTY,
    input  logic [31:0]              FIFO_DATA,
    output logic                     FIFO_READ,
    output logic                     TS_VALID,
    input  logic                     TS_READY,
    output logic [63:0]              TS_DATA,
    output logic [ERR_CNT_WIDTH-1:0] EVENT_COUNT,
    output logic [ERR_CNT_WIDTH-1:0] ERR_COUNT
);

    state_t                 state;
    logic [PAYLOAD_W-1:0]   p1;
    logic [PAYLOAD_W-1:0]   p2;

    logic [3:0]             w_id;
    logic [3:0]             w_idx;
    logic [PAYLOAD_W-1:0]   w_pay;
    logic [63:0]            assembled;
    logic                   stall;
    logic                   pop;
    logic                   id_ok;
    logic                   idx_ok;
    logic                   restart;
    logic                   complete;
    logic                   emit;
    logic                   drop;
    logic                   err_inc;

    assign w_id      = FIFO_DATA[ID_MSB:ID_LSB];
    assign w_idx     = FIFO_DATA[IDX_MSB:IDX_LSB];
    assign w_pay     = FIFO_DATA[PAYLOAD_MSB:PAYLOAD_LSB];
    assign assembled = {w_pay[15:0], p2, p1};

    // Only the final word of an event can overwrite the output, so that is the only pop ever held back.
    assign stall     = (state == WAIT3) && TS_VALID && !TS_READY;
    assign pop       = RST_N && !FIFO_EMPTY && !stall;
    assign FIFO_READ = pop;

    assign id_ok     = (w_id == IDENTIFIER);
    assign idx_ok    = id_ok && (w_idx == expected_idx(state));
    assign restart   = id_ok && !idx_ok && (w_idx == IDX_LO);
    assign complete  = pop && idx_ok && (state == WAIT3);

`ifdef TS_MONOTONIC_CHECK_EN
    logic [63:0] last_ts;
    logic        first_evt;

    assign emit = complete && (first_evt || (assembled > last_ts));
    assign drop = complete && !emit;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_ts   <= '0;
            first_evt <= 1'b1;
        end else if (emit) begin
            last_ts   <= assembled;
            first_evt <= 1'b0;
        end
    end
`else
    assign emit = complete;
    assign drop = 1'b0;
`endif

    assign err_inc = (pop && !idx_ok) || drop;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state    <= WAIT1;
            p1       <= '0;
            p2       <= '0;
            TS_VALID <= 1'b0;
            TS_DATA  <= '0;
        end else begin
            // A load in the same cycle as an accept keeps TS_VALID high with fresh data.
            if (emit) begin
                TS_DATA  <= assembled;
                TS_VALID <= 1'b1;
            end else if (TS_VALID && TS_READY) begin
                TS_VALID <= 1'b0;
            end

            if (pop && id_ok) begin
                if (idx_ok) begin
                    case (state)
                        WAIT1: begin
                            p1    <= w_pay;
                            state <= WAIT2;
                        end
                        WAIT2: begin
                            p2    <= w_pay;
                            state <= WAIT3;
                        end
                        default: state <= WAIT1;
                    endcase
                end else if (restart) begin
                    p1    <= w_pay;
                    state <= WAIT2;
                end else begin
                    state <= WAIT1;
                end
            end
        end
    end

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_event_cnt (
        .CLK   (CLK),
        .clr_n (RST_N),
        .inc   (emit),
        .count (EVENT_COUNT)
    );

    sat_counter #(.WIDTH(ERR_CNT_WIDTH)) u_err_cnt (
        .CLK   (CLK),
        .clr_n (RST_N),
        .inc   (err_inc),
        .count (ERR_COUNT)
    );

endmodule

// File: tb/tb_ts_word_aligner.sv
// Self-checking bench for ts_word_aligner: directed vector table, corner sequences, random traffic vs a queue model.
module tb_ts_word_aligner;

    logic        CLK = 1'b0;
    logic        RST_N;
    logic        FIFO_EMPTY;
    logic [31:0] FIFO_DATA;
    logic        FIFO_READ;
    logic        TS_VALID;
    logic        TS_READY;
    logic [63:0] TS_DATA;
    logic [15:0] EVENT_COUNT;
    logic [15:0] ERR_COUNT;

    always #5 CLK = ~CLK;

    ts_word_aligner dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .FIFO_EMPTY  (FIFO_EMPTY),
        .FIFO_DATA   (FIFO_DATA),
        .FIFO_READ   (FIFO_READ),
        .TS_VALID    (TS_VALID),
        .TS_READY    (TS_READY),
        .TS_DATA     (TS_DATA),
        .EVENT_COUNT (EVENT_COUNT),
        .ERR_COUNT   (ERR_COUNT)
    );

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Upstream FWFT FIFO, random word source, and reference model state.
    logic [31:0] fifo_q[$];
    logic [31:0] gen_q[$];
    logic [23:0] part_q[$];
    logic [63:0] exp_q[$];
    logic [63:0] last_acc = '0;
    int          m_err = 0;
    int          m_evt = 0;
    bit          rand_ready = 1'b0;
`ifdef TS_MONOTONIC_CHECK_EN
    logic [63:0] m_last  = '0;
    bit          m_first = 1'b1;
`endif

    task automatic drive_fifo();
        FIFO_EMPTY = (fifo_q.size() == 0);
        FIFO_DATA  = (fifo_q.size() == 0) ? 32'hDEAD_BEEF : fifo_q[0];
    endtask

    task automatic push_word(input logic [31:0] w);
        fifo_q.push_back(w);
        drive_fifo();
    endtask

    task automatic model_reset();
        part_q.delete();
        exp_q.delete();
        m_err = 0;
        m_evt = 0;
`ifdef TS_MONOTONIC_CHECK_EN
        m_last  = '0;
        m_first = 1'b1;
`endif
    endtask

    task automatic model_emit(input logic [63:0] ts);
`ifdef TS_MONOTONIC_CHECK_EN
        if (!m_first && ts <= m_last) begin
            m_err++;
            return;
        end
        m_first = 1'b0;
        m_last  = ts;
`endif
        exp_q.push_back(ts);
        m_evt++;
    endtask

    // An event is the in-order run of indices 1,2,3; the partial list length says which index comes next.
    task automatic model_word(input logic [31:0] w);
        logic [23:0] hi;
        logic [63:0] ts;
        int          idx;
        idx = int'(w[27:24]);
        if (w[31:28] != 4'h5) begin
            m_err++;
        end else if (idx == part_q.size() + 1) begin
            part_q.push_back(w[23:0]);
            if (part_q.size() == 3) begin
                hi = part_q[2];
                ts = {hi[15:0], part_q[1], part_q[0]};
                part_q.delete();
                model_emit(ts);
            end
        end else if (idx == 1) begin
            m_err++;
            part_q.delete();
            part_q.push_back(w[23:0]);
        end else begin
            m_err++;
            part_q.delete();
        end
    endtask

    // One clock: observe at the falling edge, then apply pop/accept effects just after the rising edge.
    task automatic cycle();
        bit          popping;
        bit          acc;
        logic [31:0] w;
        @(negedge CLK);
        check("fifo_read", 64'(FIFO_READ),
              64'(RST_N && fifo_q.size() != 0 &&
                  !(part_q.size() == 2 && exp_q.size() != 0 && !TS_READY)));
        check("ts_valid", 64'(TS_VALID), 64'(exp_q.size() != 0));
        if (TS_VALID && exp_q.size() != 0) check("ts_data", TS_DATA, exp_q[0]);
        check("event_count", 64'(EVENT_COUNT), 64'(m_evt));
        check("err_count", 64'(ERR_COUNT), 64'(m_err));
        popping = FIFO_READ;
        acc     = TS_VALID && TS_READY;
        @(posedge CLK);
        #1;
        if (acc && exp_q.size() != 0) last_acc = exp_q.pop_front();
        if (popping && fifo_q.size() != 0) begin
            w = fifo_q.pop_front();
            model_word(w);
        end
        if (gen_q.size() != 0 && $urandom_range(1, 0) == 1) fifo_q.push_back(gen_q.pop_front());
        if (rand_ready) TS_READY = ($urandom_range(3, 0) != 0);
        drive_fifo();
    endtask

    task automatic run_until_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            if (fifo_q.size() == 0 && gen_q.size() == 0 && exp_q.size() == 0) break;
            cycle();
        end
        check("drain_fifo_left", 64'(fifo_q.size() + gen_q.size()), 64'd0);
        check("drain_out_left", 64'(exp_q.size()), 64'd0);
    endtask

    typedef struct {
        int          n;
        logic [31:0] w [6];
        logic [63:0] ts;
        int          err;
        int          evt;
    } vec_t;

    vec_t vecs [7];
    int   tbl_err = 0;
    int   tbl_evt = 0;

    task automatic set_vec(input int i, input int n,
                           input logic [31:0] w0, input logic [31:0] w1, input logic [31:0] w2,
                           input logic [31:0] w3, input logic [31:0] w4,
                           input logic [63:0] ts, input int err, input int evt);
        vecs[i].n    = n;
        vecs[i].w[0] = w0;
        vecs[i].w[1] = w1;
        vecs[i].w[2] = w2;
        vecs[i].w[3] = w3;
        vecs[i].w[4] = w4;
        vecs[i].w[5] = 32'h0;
        vecs[i].ts   = ts;
        vecs[i].err  = err;
        vecs[i].evt  = evt;
    endtask

    task automatic reset_dut();
        RST_N = 1'b0;
        fifo_q.delete();
        model_reset();
        last_acc = '0;
        tbl_err  = 0;
        tbl_evt  = 0;
        drive_fifo();
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [63:0] ev_a;
        logic [63:0] ev_b;
        int          base_evt;
        RST_N      = 1'b0;
        TS_READY   = 1'b1;
        FIFO_EMPTY = 1'b1;
        FIFO_DATA  = 32'h0;
        #2;
        check("rst_ts_valid", 64'(TS_VALID), 64'd0);
        check("rst_ts_data", TS_DATA, 64'd0);
        check("rst_event_count", 64'(EVENT_COUNT), 64'd0);
        check("rst_err_count", 64'(ERR_COUNT), 64'd0);
        reset_dut();

`ifndef TS_MONOTONIC_CHECK_EN
        set_vec(0, 3, 32'h51000ABC, 32'h52000DEF, 32'h53001234, 32'h0, 32'h0,
                64'h1234000DEF000ABC, 0, 1);
        set_vec(1, 4, 32'h61000001, 32'h51000ABC, 32'h52000DEF, 32'h53001234, 32'h0,
                64'h1234000DEF000ABC, 1, 1);
        set_vec(2, 4, 32'h51000111, 32'h51000222, 32'h52000333, 32'h53000444, 32'h0,
                64'h0444000333000222, 1, 1);
        set_vec(3, 5, 32'h51000AAA, 32'h57000BBB, 32'h51000001, 32'h52000002, 32'h53FF0003,
                64'h0003000002000001, 1, 1);
        set_vec(4, 4, 32'h52000005, 32'h51000010, 32'h52000020, 32'h53ABCDEF, 32'h0,
                64'hCDEF000020000010, 1, 1);
        set_vec(5, 3, 32'h51FFFFFF, 32'h52FFFFFF, 32'h53FFFFFF, 32'h0, 32'h0,
                64'hFFFFFFFFFFFFFFFF, 0, 1);
        set_vec(6, 5, 32'h51000001, 32'h53000002, 32'h51000003, 32'h52000004, 32'h53000005,
                64'h0005000004000003, 1, 1);

        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < vecs[v].n; k++) push_word(vecs[v].w[k]);
            run_until_idle(50);
            tbl_err += vecs[v].err;
            tbl_evt += vecs[v].evt;
            check($sformatf("vec%0d_ts", v), last_acc, vecs[v].ts);
            check($sformatf("vec%0d_err", v), 64'(ERR_COUNT), 64'(tbl_err));
            check($sformatf("vec%0d_evt", v), 64'(EVENT_COUNT), 64'(tbl_evt));
        end

        // Back-to-back events with the consumer stalled: only the last word of event 2 waits.
        ev_a = 64'h0003000002000001;
        ev_b = 64'h0013000012000011;
        TS_READY = 1'b0;
        push_word(32'h51000001); push_word(32'h52000002); push_word(32'h53000003);
        push_word(32'h51000011); push_word(32'h52000012); push_word(32'h53000013);
        repeat (10) cycle();
        check("stall_words_left", 64'(fifo_q.size()), 64'd1);
        check("stall_ts_valid", 64'(TS_VALID), 64'd1);
        check("stall_ts_data", TS_DATA, ev_a);
        TS_READY = 1'b1;
        cycle();
        check("stall_accepted", last_acc, ev_a);
        check("stall_next_valid", 64'(TS_VALID), 64'd1);
        check("stall_next_data", TS_DATA, ev_b);
        run_until_idle(20);
        tbl_evt += 2;
        check("stall_last", last_acc, ev_b);
        check("stall_evt", 64'(EVENT_COUNT), 64'(tbl_evt));

        // Throughput: four events, twelve pops, twelve clocks.
        base_evt = tbl_evt;
        for (int e = 0; e < 4; e++) begin
            push_word(32'h51000000 | 32'(e));
            push_word(32'h52000100 | 32'(e));
            push_word(32'h53000200 | 32'(e));
        end
        repeat (12) cycle();
        check("thru_evt", 64'(EVENT_COUNT), 64'(base_evt + 4));
        check("thru_fifo_left", 64'(fifo_q.size()), 64'd0);
        run_until_idle(10);
        check("thru_last", last_acc, 64'h0203000103000003);

        // Reset in the middle of an event.
        push_word(32'h51000100);
        push_word(32'h52000200);
        repeat (3) cycle();
        RST_N = 1'b0;
        model_reset();
        push_word(32'h53000300);
        #2;
        check("mid_rst_read", 64'(FIFO_READ), 64'd0);
        check("mid_rst_valid", 64'(TS_VALID), 64'd0);
        check("mid_rst_data", TS_DATA, 64'd0);
        check("mid_rst_evt", 64'(EVENT_COUNT), 64'd0);
        check("mid_rst_err", 64'(ERR_COUNT), 64'd0);
        repeat (2) cycle();
        fifo_q.delete();
        drive_fifo();
        RST_N = 1'b1;
        push_word(32'h51000007); push_word(32'h52000008); push_word(32'h53000009);
        run_until_idle(20);
        check("post_rst_ts", last_acc, 64'h0009000008000007);
        check("post_rst_err", 64'(ERR_COUNT), 64'd0);
        check("post_rst_evt", 64'(EVENT_COUNT), 64'd1);
`else
        // Monotonic filter: 100 then 50.
        push_word(32'h51000064); push_word(32'h52000000); push_word(32'h53000000);
        run_until_idle(20);
        check("mono_first", last_acc, 64'd100);
        push_word(32'h51000032); push_word(32'h52000000); push_word(32'h53000000);
        run_until_idle(20);
        check("mono_last", last_acc, 64'd100);
        check("mono_err", 64'(ERR_COUNT), 64'd1);
        check("mono_evt", 64'(EVENT_COUNT), 64'd1);
`endif

        // Random traffic with a randomly stalling consumer.
        rand_ready = 1'b1;
        for (int e = 0; e < 150; e++) begin
            int r;
            r = int'($urandom_range(9, 0));
            if (r < 7) begin
                gen_q.push_back({8'h51, 24'($urandom)});
                gen_q.push_back({8'h52, 24'($urandom)});
                gen_q.push_back({8'h53, 24'($urandom)});
            end else if (r == 7) begin
                gen_q.push_back({4'($urandom_range(15, 6)), 4'($urandom_range(3, 1)), 24'($urandom)});
            end else if (r == 8) begin
                gen_q.push_back({4'h5, 4'($urandom), 24'($urandom)});
            end else begin
                gen_q.push_back({8'h51, 24'($urandom)});
            end
        end
        run_until_idle(5000);
        rand_ready = 1'b0;
        TS_READY   = 1'b1;
        check("rand_evt", 64'(EVENT_COUNT), 64'(m_evt));
        check("rand_err", 64'(ERR_COUNT), 64'(m_err));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/ts_word_aligner.md
Name: ts_word_aligner

Overview:
- Downstream consumer of the timestamp block's 32-bit word FIFO interface (FIFO_READ / FIFO_EMPTY / FIFO_DATA).
- Pulls three tagged words per event and checks identifier and word order.
- Reassembles each event into one 64-bit timestamp, presented on a valid/ready stream.
- Sits between the timestamp block and on-chip consumers (e.g. coincidence or trigger logic) that need full timestamps rather than a raw readout stream.

Parameters:
- IDENTIFIER, 4'b0101: expected value of word bits [31:28]; other words are discarded.
- ERR_CNT_WIDTH, 16: width of the saturating error and event counters.

Ports:
- CLK  input  1  single clock; all logic is rising-edge.
- RST_N  input  1  asynchronous active-low reset.
- FIFO_EMPTY  input  1  upstream FIFO empty; FIFO_DATA is valid when low (first-word-fall-through).
- FIFO_DATA  input  32  upstream word.
- FIFO_READ  output  1  pops the current upstream word this cycle.
- TS_VALID  output  1  TS_DATA holds an assembled timestamp.
- TS_READY  input  1  downstream accepts when TS_VALID && TS_READY.
- TS_DATA  output  64  assembled timestamp.
- EVENT_COUNT  output  ERR_CNT_WIDTH  events emitted; saturating.
- ERR_COUNT  output  ERR_CNT_WIDTH  discarded or aborted words; saturating.

Behaviour:
- Word format:
  - [31:28] ID.
  - [27:24] index: 1, 2 or 3.
  - [23:0] payload.
  - Index 1 supplies ts[23:0]; index 2 supplies ts[47:24]; index 3 supplies ts[63:48] from payload[15:0]. Payload[23:16] of index 3 is ignored.
- Reset (RST_N low, asynchronous): state=WAIT1, TS_VALID=0, TS_DATA=0, EVENT_COUNT=0, ERR_COUNT=0, partial register=0. FIFO_READ is combinationally 0 while RST_N is low.
- FIFO_READ = !FIFO_EMPTY && !(state==WAIT3 && TS_VALID && !TS_READY).
  - The block never stalls except when popping the final word would overwrite an unaccepted output.
- State machine: WAIT1 -> WAIT2 -> WAIT3 -> WAIT1. Actions on each popped word:
  - ID != IDENTIFIER: discard, ERR_COUNT+1, state unchanged.
  - Index equals the expected index: store payload, advance state.
  - Unexpected index 1 in WAIT2/WAIT3: abort the partial event, ERR_COUNT+1, store the payload as a new index 1, go to WAIT2.
  - Any other unexpected index (including 0 or >3): discard the word and any partial event, ERR_COUNT+1, go to WAIT1.
  - Valid index 3 in WAIT3: TS_DATA <= {payload[15:0], p2, p1}; TS_VALID <= 1 the next cycle (latency 1 clock from pop); EVENT_COUNT+1; go to WAIT1.
- Output handshake:
  - TS_VALID clears on TS_VALID && TS_READY, unless a new event loads in the same cycle; in that case it stays 1 and TS_DATA is updated.
  - TS_DATA is stable while TS_VALID && !TS_READY.
- Throughput: one event per 3 clocks with TS_READY held high.
- Counters saturate at all-ones. If ERR and EVENT increments coincide, both apply.
- Reset mid-event drops the partial event silently; no ERR increment.

Optional Feature:
- Macro: TS_MONOTONIC_CHECK_EN.
- With the macro defined:
  - A 64-bit register holds the last emitted timestamp (reset 0) plus a first-event flag.
  - An assembled timestamp not strictly greater than the last is dropped: no TS_VALID, ERR_COUNT+1, last value unchanged.
  - The first event after reset is always accepted.
- Without the macro: no comparison and no extra registers; every correctly ordered event is emitted.

Decomposition:
- Package ts_word_aligner_pkg:
  - State enum (WAIT1, WAIT2, WAIT3).
  - Index constants IDX_LO=1, IDX_MID=2, IDX_HI=3.
  - Field position constants (ID, IDX, PAYLOAD bit ranges).
- One sub-module, sat_counter (WIDTH parameter, inc input, async active-low clear), instantiated twice, for EVENT_COUNT and ERR_COUNT.

Test Plan:
1. Words 0x51_000ABC, 0x52_000DEF, 0x53_001234 with TS_READY=1 -> one cycle after the third pop, TS_VALID=1 and TS_DATA=0x1234_000DEF_000ABC; EVENT_COUNT=1, ERR_COUNT=0.
2. Word 0x61_000001 followed by the event from scenario 1 -> first word discarded, ERR_COUNT=1; correct TS_DATA emitted, EVENT_COUNT=1.
3. Sequence idx1, idx1, idx2, idx3 -> ERR_COUNT=1; emitted event uses the second idx1 payload.
4. Two back-to-back events with TS_READY=0 -> after the first event, FIFO_READ deasserts once in WAIT3 and TS_DATA holds event 1; raising TS_READY yields event 2 on the next cycle; no words are lost.
5. Assert RST_N low after idx2 is popped, then release and send a full event -> all outputs 0 during reset; only the new event is emitted; ERR_COUNT=0.
6. With TS_MONOTONIC_CHECK_EN defined, send timestamp 100 then 50 -> 100 emitted; 50 dropped, ERR_COUNT=1.
